// File: rtl/fifo3_sync.sv
`default_nettype none
// ============================================================================
// Module   : fifo3_sync
// Purpose  : Single-clock synchronous FIFO with occupancy count, almost-full /
//            almost-empty thresholds, optional first-word-fall-through read
//            and sticky overflow/underflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module fifo3_sync #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 6,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = 60,
  parameter int AEMPTY_TH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  output logic             wafull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             raempty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);

  localparam int DEPTH = 1 << ASIZE;

  // Thresholds widened by one bit so DEPTH itself is representable in compares
  localparam logic [ASIZE+1:0] C_DEPTH     = (ASIZE+2)'(DEPTH);
  localparam logic [ASIZE+1:0] C_AFULL_TH  = (ASIZE+2)'(AFULL_TH);
  localparam logic [ASIZE+1:0] C_AEMPTY_TH = (ASIZE+2)'(AEMPTY_TH);
  localparam logic [ASIZE:0]   C_ONE       = (ASIZE+1)'(1);

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr;
  logic [ASIZE:0]   rptr;
  logic [ASIZE:0]   count_next;
  logic [ASIZE+1:0] count_ext;
  logic             wr_en;
  logic             rd_en;
  logic             ptr_msb_unused;

  // Requests are qualified by the registered flags, so a write to a full FIFO
  // or a read from an empty one is simply dropped.
  assign wr_en     = winc && !wfull;
  assign rd_en     = rinc && !rempty;
  assign count_ext = {1'b0, count_next};

  // Wrap bits are carried for pointer-debug visibility; only the low bits
  // address memory because occupancy is tracked in the count register.
  assign ptr_msb_unused = wptr[ASIZE] ^ rptr[ASIZE];

  // Next-state occupancy: simultaneous accepted write+read leaves it unchanged
  always_comb begin
    count_next = count;
    if (wr_en && !rd_en) begin
      count_next = count + C_ONE;
    end else if (rd_en && !wr_en) begin
      count_next = count - C_ONE;
    end
  end

  // Pointers, occupancy and status flags (flags use next-state count)
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      wfull   <= 1'b0;
      rempty  <= 1'b1;
      wafull  <= 1'b0;
      raempty <= 1'b1;
    end else begin
      if (wr_en) begin
        wptr <= wptr + C_ONE;
      end
      if (rd_en) begin
        rptr <= rptr + C_ONE;
      end
      count   <= count_next;
      wfull   <= (count_ext == C_DEPTH);
      rempty  <= (count_next == '0);
      wafull  <= (count_ext >= C_AFULL_TH);
      raempty <= (count_ext <= C_AEMPTY_TH);
    end
  end

  // Storage array; not reset, and reset blocks a same-cycle write
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wptr[ASIZE-1:0]] <= wdata;
    end
  end

  // Sticky error flags; a new error event wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (winc && wfull)  || (overflow  && !err_clr);
      underflow <= (rinc && rempty) || (underflow && !err_clr);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented directly from memory at the read pointer
      assign rdata = mem[rptr[ASIZE-1:0]];
    end else begin : g_reg_read
      logic [DSIZE-1:0] rdata_r;

      // Registered read port: loads only on an accepted read, else holds
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_r <= '0;
        end else if (rd_en) begin
          rdata_r <= mem[rptr[ASIZE-1:0]];
        end
      end

      assign rdata = rdata_r;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fifo3_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo3_sync
// Purpose  : Self-checking bench for fifo3_sync (registered and FWFT modes)
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo3_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] wdata = '0;
  logic       winc = 1'b0;
  logic       rinc = 1'b0;
  logic       err_clr = 1'b0;
  logic       wfull, wafull, rempty, raempty, overflow, underflow;
  logic [7:0] rdata;
  logic [6:0] count;

  logic [7:0] f_wdata = '0;
  logic       f_winc = 1'b0;
  logic       f_rinc = 1'b0;
  logic       f_err_clr = 1'b0;
  logic       f_wfull, f_wafull, f_rempty, f_raempty, f_overflow, f_underflow;
  logic [7:0] f_rdata;
  logic [6:0] f_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard / reference state for the registered-read instance
  logic [7:0] q[$];
  int         m_cnt = 0;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic [7:0] m_rd  = '0;

  always #5 clk = ~clk;

  fifo3_sync #(.DSIZE(8), .ASIZE(6), .FWFT(0), .AFULL_TH(60), .AEMPTY_TH(4)) dut (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .wfull(wfull), .wafull(wafull),
    .rinc(rinc), .rdata(rdata), .rempty(rempty), .raempty(raempty), .count(count),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );

  fifo3_sync #(.DSIZE(8), .ASIZE(6), .FWFT(1), .AFULL_TH(60), .AEMPTY_TH(4)) dut_ft (
    .clk(clk), .rst(rst), .wdata(f_wdata), .winc(f_winc), .wfull(f_wfull), .wafull(f_wafull),
    .rinc(f_rinc), .rdata(f_rdata), .rempty(f_rempty), .raempty(f_raempty), .count(f_count),
    .overflow(f_overflow), .underflow(f_underflow), .err_clr(f_err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus on the registered-read instance, with reference update and checks
  task automatic step(input logic rs, input logic w, input logic [7:0] d,
                      input logic r, input logic clr);
    bit was_full, was_empty, wa, ra;
    was_full  = (m_cnt == 64);
    was_empty = (m_cnt == 0);
    if (rs) begin
      q.delete();
      m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0; m_rd = '0;
    end else begin
      wa = w && !was_full;
      ra = r && !was_empty;
      if (ra) m_rd = q.pop_front();
      if (wa) q.push_back(d);
      m_cnt = m_cnt + int'(wa) - int'(ra);
      m_ovf = (w && was_full)  || (m_ovf && !clr);
      m_unf = (r && was_empty) || (m_unf && !clr);
    end
    rst = rs; winc = w; wdata = d; rinc = r; err_clr = clr;
    @(posedge clk);
    #1;
    rst = 1'b0; winc = 1'b0; rinc = 1'b0; err_clr = 1'b0;
    chk("count",     32'(count),     32'(m_cnt));
    chk("wfull",     32'(wfull),     32'(m_cnt == 64));
    chk("rempty",    32'(rempty),    32'(m_cnt == 0));
    chk("wafull",    32'(wafull),    32'(m_cnt >= 60));
    chk("raempty",   32'(raempty),   32'(m_cnt <= 4));
    chk("overflow",  32'(overflow),  32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    chk("rdata",     32'(rdata),     32'(m_rd));
  endtask

  task automatic f_step(input logic w, input logic [7:0] d, input logic r);
    f_winc = w; f_wdata = d; f_rinc = r;
    @(posedge clk);
    #1;
    f_winc = 1'b0; f_rinc = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(1, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);

    // Fill 0x01..0x40, then one write too many
    for (int i = 1; i <= 64; i++) step(0, 1, 8'(i), 0, 0);
    step(0, 1, 8'hEE, 0, 0);

    // Drain in order, then one read too many
    for (int i = 1; i <= 64; i++) step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 0);
    chk("rdata_hold_after_underflow", 32'(rdata), 32'h40);
    step(0, 0, 8'h00, 0, 1);

    // Wrap-around at constant occupancy of 10
    for (int i = 0; i < 10; i++) step(0, 1, 8'($urandom_range(0, 255)), 0, 0);
    for (int i = 0; i < 200; i++) step(0, 1, 8'($urandom_range(0, 255)), 1, 0);

    // Boundary simultaneity at empty and at full
    for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 1, 0);
    step(0, 1, 8'h5A, 1, 0);
    step(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 63; i++) step(0, 1, 8'($urandom_range(0, 255)), 0, 0);
    step(0, 1, 8'hC3, 1, 0);
    chk("count_after_full_wr_rd", 32'(count), 32'd63);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Reset mid-operation at count 37 with write and read requested
    for (int i = 0; i < 26; i++) step(0, 0, 8'h00, 1, 0);
    chk("count_before_reset", 32'(count), 32'd37);
    step(1, 1, 8'h77, 1, 0);

    // First-word-fall-through instance
    f_step(1, 8'hA5, 0);
    chk("ft_rdata_a5", 32'(f_rdata), 32'hA5);
    chk("ft_rempty_after_wr", 32'(f_rempty), 32'd0);
    chk("ft_count_after_wr", 32'(f_count), 32'd1);
    f_step(0, 8'h00, 1);
    chk("ft_rempty_after_pop", 32'(f_rempty), 32'd1);
    chk("ft_count_after_pop", 32'(f_count), 32'd0);
    f_step(1, 8'h11, 0);
    f_step(1, 8'h22, 0);
    chk("ft_rdata_head", 32'(f_rdata), 32'h11);
    f_step(0, 8'h00, 1);
    chk("ft_rdata_next", 32'(f_rdata), 32'h22);
    f_step(0, 8'h00, 1);
    chk("ft_rempty_final", 32'(f_rempty), 32'd1);
    chk("ft_underflow_clear", 32'(f_underflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
